// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined RV32I/RV64I immediate generator with valid/ready slices
// Define IMM_ZIMM_EN to decode ImmSrc 101 as CSR zimm; otherwise 101 is reserved.
module imm_extend_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       ImmSrc,
    input  logic [24:0]      Instr,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [XLEN-1:0]  ExtImm,
    output logic [TAG_W-1:0] OutTag,
    output logic             Illegal,
    output logic [7:0]       IllegalCnt
);

    // Instr[k] holds full instruction bit k+7.
    logic [31:0]     imm32;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        imm32   = '0;
        dec_ill = 1'b0;
        case (ImmSrc)
            3'b000: imm32 = {{20{Instr[24]}}, Instr[24:13]};
            3'b001: imm32 = {{20{Instr[24]}}, Instr[24:18], Instr[4:0]};
            3'b010: imm32 = {{20{Instr[24]}}, Instr[0], Instr[23:18], Instr[4:1], 1'b0};
            3'b011: imm32 = {Instr[24:5], 12'b0};
            3'b100: imm32 = {{12{Instr[24]}}, Instr[12:5], Instr[13], Instr[23:14], 1'b0};
`ifdef IMM_ZIMM_EN
            3'b101: imm32 = {27'b0, Instr[12:8]};
`endif
            default: dec_ill = 1'b1;
        endcase
        // zimm has bit 31 clear, so sign extension doubles as its zero extension.
        dec_imm = XLEN'($signed(imm32));
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [XLEN-1:0]   data_q [STAGES];
    logic [XLEN-1:0]   data_d [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];
    logic [STAGES-1:0] ill_q, ill_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [STAGES-1:0] rdy;
    logic              rdy_acc;

    // A slice is ready if it or any slice downstream of it has a hole, or the sink drains.
    always_comb begin
        rdy_acc = OutReady;
        rdy     = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy_acc = rdy_acc || !valid_q[k];
            rdy[k]  = rdy_acc;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        if (rdy[0]) begin
            valid_d[0] = InValid;
            if (InValid) begin
                data_d[0] = dec_imm;
                tag_d[0]  = InTag;
                ill_d[0]  = dec_ill;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    tag_d[k]  = tag_q[k-1];
                    ill_d[k]  = ill_q[k-1];
                end
            end
        end
        if (InValid && rdy[0] && dec_ill && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ill_q   <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InReady    = rdy[0];
    assign OutValid   = valid_q[STAGES-1];
    assign ExtImm     = data_q[STAGES-1];
    assign OutTag     = tag_q[STAGES-1];
    assign Illegal    = ill_q[STAGES-1];
    assign IllegalCnt = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - self-checking bench for imm_extend_pipe (32- and 64-bit instances)
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InValid;
    logic        OutReady;
    logic [2:0]  ImmSrc;
    logic [24:0] Instr;
    logic [4:0]  InTag;

    logic        InReady, OutValid, Illegal;
    logic [31:0] ExtImm;
    logic [4:0]  OutTag;
    logic [7:0]  IllegalCnt;

    logic        InReady64, OutValid64, Illegal64;
    logic [63:0] ExtImm64;
    logic [4:0]  OutTag64;
    logic [7:0]  IllegalCnt64;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
        .ImmSrc(ImmSrc), .Instr(Instr), .InTag(InTag), .OutValid(OutValid),
        .OutReady(OutReady), .ExtImm(ExtImm), .OutTag(OutTag),
        .Illegal(Illegal), .IllegalCnt(IllegalCnt)
    );

    imm_extend_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady64),
        .ImmSrc(ImmSrc), .Instr(Instr), .InTag(InTag), .OutValid(OutValid64),
        .OutReady(OutReady), .ExtImm(ExtImm64), .OutTag(OutTag64),
        .Illegal(Illegal64), .IllegalCnt(IllegalCnt64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } ent_t;

    ent_t q[$];
    int   mcnt = 0;
    int   log_tag[$];
    int   log_cyc[$];
    bit   hold_v = 0;
    logic [63:0] hold_imm;
    logic [4:0]  hold_tag;
    logic        hold_ill;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Immediates rebuilt bit-field by bit-field with shifts on a 64-bit value.
    function automatic ent_t model(input logic [2:0] src, input logic [31:0] i, input logic [4:0] tag);
        ent_t r;
        logic [63:0] sx;
        sx    = {64{i[31]}};
        r.tag = tag;
        r.ill = 1'b0;
        r.imm = 64'd0;
        case (src)
            3'd0: r.imm = (sx << 12) | 64'(i[31:20]);
            3'd1: r.imm = (sx << 12) | (64'(i[31:25]) << 5) | 64'(i[11:7]);
            3'd2: r.imm = (sx << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
            3'd3: r.imm = (sx << 32) | 64'(i & 32'hFFFFF000);
            3'd4: r.imm = (sx << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
`ifdef IMM_ZIMM_EN
            3'd5: r.imm = 64'(i[19:15]);
`endif
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // Scoreboard: every cycle compare outputs against the head of the expected queue.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            mcnt   = 0;
            hold_v = 0;
        end else begin
            chk("illegal_cnt", 64'(IllegalCnt), 64'(mcnt));
            chk("illegal_cnt64", 64'(IllegalCnt64), 64'(mcnt));
            chk("in_ready64", 64'(InReady64), 64'(InReady));
            chk("out_valid64", 64'(OutValid64), 64'(OutValid));
            if (hold_v) begin
                chk("hold_valid", 64'(OutValid), 64'd1);
                chk("hold_imm", ExtImm64, hold_imm);
                chk("hold_tag", 64'(OutTag), 64'(hold_tag));
                chk("hold_ill", 64'(Illegal), 64'(hold_ill));
            end
            if (OutValid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'(OutValid), 64'd0);
                end else begin
                    chk("imm32", 64'(ExtImm), 64'(q[0].imm[31:0]));
                    chk("imm64", ExtImm64, q[0].imm);
                    chk("tag", 64'(OutTag), 64'(q[0].tag));
                    chk("tag64", 64'(OutTag64), 64'(q[0].tag));
                    chk("ill", 64'(Illegal), 64'(q[0].ill));
                    chk("ill64", 64'(Illegal64), 64'(q[0].ill));
                    if (OutReady) begin
                        void'(q.pop_front());
                        log_tag.push_back(int'(OutTag));
                        log_cyc.push_back(cyc);
                    end
                end
            end
            hold_v   = OutValid && !OutReady;
            hold_imm = ExtImm64;
            hold_tag = OutTag;
            hold_ill = Illegal;
            if (InValid && InReady) begin
                ent_t e;
                e = model(ImmSrc, {Instr, 7'b0}, InTag);
                q.push_back(e);
                if (e.ill && mcnt < 255) mcnt++;
            end
        end
    end

    task automatic send(input logic [2:0] src, input logic [31:0] ins, input logic [4:0] tag);
        bit ok;
        int n;
        ok      = 0;
        n       = 0;
        InValid = 1'b1;
        ImmSrc  = src;
        Instr   = ins[31:7];
        InTag   = tag;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = InReady;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accept", 64'(ok), 64'd1);
        InValid = 1'b0;
    endtask

    task automatic single(input string name, input logic [2:0] src, input logic [31:0] ins,
                          input logic [31:0] exp32, input logic [63:0] exp64, input logic exp_ill);
        int n;
        send(src, ins, 5'd9);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!OutValid && n < 10);
        chk({name, "_latency"}, 64'(n), 64'd2);
        chk({name, "_imm32"}, 64'(ExtImm), 64'(exp32));
        chk({name, "_imm64"}, ExtImm64, exp64);
        chk({name, "_ill"}, 64'(Illegal), 64'(exp_ill));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        ImmSrc   = 3'd0;
        Instr    = '0;
        InTag    = '0;
        #2;
        chk("rst_out_valid", 64'(OutValid), 64'd0);
        chk("rst_ext_imm", ExtImm64, 64'd0);
        chk("rst_out_tag", 64'(OutTag), 64'd0);
        chk("rst_illegal", 64'(Illegal), 64'd0);
        chk("rst_cnt", 64'(IllegalCnt), 64'd0);
        chk("rst_in_ready", 64'(InReady), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        single("fmt_i", 3'd0, 32'h0FF00FF0, 32'h000000FF, 64'h00000000000000FF, 1'b0);
        single("fmt_s", 3'd1, 32'hFFFFFF80, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        single("fmt_b", 3'd2, 32'h80000F80, 32'hFFFFF81E, 64'hFFFFFFFFFFFFF81E, 1'b0);
        single("fmt_j", 3'd4, 32'h00100000, 32'h00000800, 64'h0000000000000800, 1'b0);
        single("fmt_u", 3'd3, 32'h12345000, 32'h12345000, 64'h0000000012345000, 1'b0);
        single("u_neg", 3'd3, 32'h80000000, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        single("i_neg", 3'd0, 32'hFFF00000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send(3'(i % 5), $urandom, 5'(i));
        end
        repeat (4) @(posedge clk);
        #1;

        OutReady = 1'b0;
        log_tag.delete();
        log_cyc.delete();
        send(3'd0, 32'h00100000, 5'd1);
        send(3'd1, 32'h00000080, 5'd2);
        @(negedge clk);
        chk("bp_in_ready", 64'(InReady), 64'd0);
        fork
            begin
                send(3'd2, 32'h80000F80, 5'd3);
                send(3'd4, 32'h00100000, 5'd4);
            end
            begin
                repeat (3) @(posedge clk);
                #1 OutReady = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("bp_count", 64'(log_tag.size()), 64'd4);
        if (log_tag.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("bp_order", 64'(log_tag[i]), 64'(i + 1));
                if (i > 0) chk("bp_no_gap", 64'(log_cyc[i] - log_cyc[i-1]), 64'd1);
            end
        end

`ifdef IMM_ZIMM_EN
        single("zimm", 3'd5, 32'h000F8000, 32'h0000001F, 64'h000000000000001F, 1'b0);
        chk("zimm_cnt", 64'(IllegalCnt), 64'd0);
`else
        single("zimm", 3'd5, 32'h000F8000, 32'h00000000, 64'h0000000000000000, 1'b1);
        chk("zimm_cnt", 64'(IllegalCnt), 64'd1);
`endif

        for (int i = 0; i < 300; i++) begin
            send((i % 7 == 3) ? 3'd6 : 3'd7, $urandom, 5'(i));
        end
        repeat (4) @(posedge clk);
        #1;
        chk("sat_cnt", 64'(IllegalCnt), 64'd255);
        chk("sat_cnt64", 64'(IllegalCnt64), 64'd255);

        OutReady = 1'b0;
        send(3'd0, 32'h0FF00FF0, 5'd21);
        send(3'd7, 32'h0, 5'd22);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(OutValid), 64'd0);
        chk("midrst_out_valid64", 64'(OutValid64), 64'd0);
        chk("midrst_cnt", 64'(IllegalCnt), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        OutReady = 1'b1;
        log_tag.delete();
        log_cyc.delete();
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_stale", 64'(log_tag.size()), 64'd0);
        chk("midrst_cnt_after", 64'(IllegalCnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate generator for the RV32I/RV64I datapath: the successor to the single-cycle `extend` block. It decodes all base immediate formats (I, S, B, U, J), plus an optional CSR zimm format, from instruction bits [31:7]. The result is sign- or zero-extended to XLEN and carried through STAGES registered slices with valid/ready flow control and a passthrough tag. It sits between fetch/decode and the execute operand mux in the pipelined core.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- STAGES, 2, number of register slices between input and output; legal range 1..4.
- TAG_W, 5, width of the sideband tag carried alongside each immediate (e.g. rd index).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- InValid  input  1  upstream has a request.
- InReady  output  1  block accepts the request this cycle.
- ImmSrc  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 zimm, 110/111 reserved.
- Instr  input  25  instruction bits [31:7].
- InTag  input  TAG_W  sideband tag.
- OutValid  output  1  ExtImm/OutTag/Illegal are valid.
- OutReady  input  1  downstream consumes the result this cycle.
- ExtImm  output  XLEN  extended immediate.
- OutTag  output  TAG_W  tag of the result.
- Illegal  output  1  the result came from a reserved or disabled ImmSrc.
- IllegalCnt  output  8  saturating count of accepted illegal requests.

## Operation
- Decode is combinational at the input. Bit numbers below refer to full instruction bits.
- I: Instr[31:20].
- S: {Instr[31:25], Instr[11:7]}.
- B: {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0}.
- U: {Instr[31:12], 12'b0}.
- J: {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0}.
- I/S/B/J results are sign-extended from Instr[31] to XLEN. For XLEN=64, U is also sign-extended from bit 31.
- zimm: Instr[19:15], zero-extended to XLEN.
- Reserved or disabled ImmSrc: ExtImm = 0 and Illegal = 1.
- Each slice k holds valid_k, data, tag and illegal.
  - Slice k may load when it is empty or its contents leave this cycle: ready_k = !valid_k || ready_{k+1}.
  - The last slice uses ready_{STAGES+1} = OutReady.
- InReady = ready_1. An accept occurs when InValid && InReady.
- The outputs are driven from the last slice. Order is preserved. There is no drop and no duplication.
- IllegalCnt increments by 1 on each accepted illegal request and saturates at 255. Counting happens at input acceptance, not at output.
- Holds while OutValid=1 and OutReady=0:
  - Output data, tag and Illegal stay stable.
  - Slices refill until all are full, then InReady=0.

## Timing
- Reset (asynchronous assert, synchronous release): all valid_k=0, OutValid=0, ExtImm=0, OutTag=0, Illegal=0, IllegalCnt=0.
- Latency: a request accepted at edge n appears with OutValid=1 after edge n+STAGES-1, i.e. STAGES cycles of registered delay with no stall.
- Throughput: one result per cycle when OutReady is held at 1.
- InReady is combinational from OutReady through the ready chain. There are no combinational paths from InValid to OutValid.
- Reset asserted mid-stream: in-flight entries are discarded, OutValid drops immediately, and IllegalCnt clears.
- Illegal accept while IllegalCnt=255: the count stays at 255.
- Simultaneous accept and drain on a full pipe: the transfer proceeds with no bubble.

## Configuration
- IMM_ZIMM_EN defined: ImmSrc 101 decodes as CSR zimm (Instr[19:15], zero-extended), with Illegal=0.
- IMM_ZIMM_EN undefined: ImmSrc 101 is reserved. The result is ExtImm=0 and Illegal=1, and IllegalCnt increments.

## Test plan
- Formats, XLEN=32, STAGES=2, OutReady=1. Each result must appear 2 cycles after accept:
  - I with Instr=0x0FF00FF0 -> 0x000000FF.
  - S with 0xFFFFFF80 -> 0xFFFFFFFF.
  - B with 0x80000F80 -> 0xFFFFF81E.
  - J with 0x00100000 -> 0x00000800.
  - U with 0x12345000 -> 0x12345000.
- XLEN=64, U with Instr=0x80000000 -> ExtImm=0xFFFFFFFF80000000. I with 0xFFF00000 -> 0xFFFFFFFFFFFFFFFF.
- Backpressure, STAGES=2: stream tags 1..4 with OutReady=0 for 5 cycles.
  - InReady=0 after 2 accepts.
  - On release, tags emerge in order 1, 2, 3, 4 with no gaps.
- Zimm: ImmSrc=101 with Instr=0x000F8000.
  - With IMM_ZIMM_EN: ExtImm=0x1F, Illegal=0.
  - Without IMM_ZIMM_EN: ExtImm=0, Illegal=1, IllegalCnt=1.
- Saturation: 300 accepted requests with ImmSrc=111 -> IllegalCnt=255 and every result shows Illegal=1, ExtImm=0.
- Reset mid-flight: pulse rst_n low with 2 entries in flight -> OutValid=0 immediately, IllegalCnt=0, and no stale result after release.
